// File: rtl/gray_counter.sv
// Up/down counter presenting its count as registered Gray code, with load,
// wrap and step strobes for downstream capture logic.
module gray_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         dir,
   input  logic         ld,
   input  logic [W-1:0] ld_g,
   output logic [W-1:0] g,
   output logic         wrap,
   output logic         step
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt;
   logic [W-1:0] ld_bin;
   logic [W-1:0] next_cnt;
   logic         wrap_hit;

   // Gray-to-binary of the load value: each binary bit is the XOR of all
   // Gray bits at or above it, built MSB-first.
   always_comb begin
      ld_bin        = '0;
      ld_bin[W-1]   = ld_g[W-1];
      for (int unsigned k = 1; k < W; k++) begin
         ld_bin[W-1-k] = ld_bin[W-k] ^ ld_g[W-1-k];
      end
   end

   always_comb begin
      next_cnt = dir ? (cnt + ONE) : (cnt - ONE);
      wrap_hit = dir ? (cnt == '1) : (cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         g    <= '0;
         wrap <= 1'b0;
         step <= 1'b0;
      end else if (ld) begin
         cnt  <= ld_bin;
         g    <= ld_g;
         wrap <= 1'b0;
         step <= 1'b1;
      end else if (en) begin
         cnt  <= next_cnt;
         g    <= next_cnt ^ (next_cnt >> 1);
         wrap <= wrap_hit;
         step <= 1'b1;
      end else begin
         wrap <= 1'b0;
         step <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (W = 4): directed scenarios plus a
// randomized run against a table-driven reflected-Gray reference model.
module tb_gray_counter;

   localparam int W = 4;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic         ld = 1'b0;
   logic [W-1:0] ld_g = '0;
   logic [W-1:0] g;
   logic         wrap;
   logic         step;

   int total = 0;
   int bad = 0;

   // Reference model: reflected Gray table and its inverse.
   logic [W-1:0] gtab [N];
   int           inv  [N];
   int           m_cnt = 0;
   logic         m_wrap = 1'b0;
   logic         m_step = 1'b0;
   logic [W-1:0] prev_g;

   gray_counter #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .dir  (dir),
      .ld   (ld),
      .ld_g (ld_g),
      .g    (g),
      .wrap (wrap),
      .step (step)
   );

   always #5 clk = ~clk;

   task automatic build_tables();
      gtab[0] = '0;
      for (int k = 0; k < W; k++) begin
         for (int i = 0; i < (1 << k); i++) begin
            gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | W'(1 << k);
         end
      end
      for (int i = 0; i < N; i++) inv[gtab[i]] = i;
   endtask

   // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic tick(input logic r, input logic l, input logic e, input logic d,
                       input logic [W-1:0] lg);
      rst = r; ld = l; en = e; dir = d; ld_g = lg;
      if (r) begin
         m_cnt = 0; m_wrap = 1'b0; m_step = 1'b0;
      end else if (l) begin
         m_cnt = inv[lg]; m_wrap = 1'b0; m_step = 1'b1;
      end else if (e) begin
         m_wrap = d ? (m_cnt == N - 1) : (m_cnt == 0);
         m_cnt  = d ? (m_cnt + 1) % N : (m_cnt + N - 1) % N;
         m_step = 1'b1;
      end else begin
         m_wrap = 1'b0; m_step = 1'b0;
      end
      prev_g = g;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
         total++;
         if ({g, wrap, step} !== {4'b0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset[%0d]: g=%b wrap=%b step=%b, want g=0000 wrap=0 step=0",
                     i, g, wrap, step);
         end
      end
   endtask

   task automatic test_up_sweep();
      logic [W-1:0] seq [17];
      seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
              4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000,
              4'b0001};
      tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 17; i++) begin
         tick(1'b0, 1'b0, 1'b1, 1'b1, '0);
         total++;
         if ({g, wrap, step} !== {seq[i], (i == 15), 1'b1}) begin
            bad++;
            $display("FAIL up_sweep[%0d]: g=%b wrap=%b step=%b, want g=%b wrap=%b step=1",
                     i, g, wrap, step, seq[i], (i == 15));
         end
         total++;
         if ($countones(g ^ prev_g) != 1) begin
            bad++;
            $display("FAIL up_onehot[%0d]: g_old=%b g_new=%b, want one bit changed",
                     i, prev_g, g);
         end
      end
   endtask

   task automatic test_down_wrap();
      tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
      total++;
      if ({g, wrap, step} !== {4'b1000, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL down_wrap: g=%b wrap=%b step=%b, want g=1000 wrap=1 step=1",
                  g, wrap, step);
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
      total++;
      if ({g, wrap, step} !== {4'b1001, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL down_after_wrap: g=%b wrap=%b step=%b, want g=1001 wrap=0 step=1",
                  g, wrap, step);
      end
   endtask

   task automatic test_load_then_count();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 4'b1011);
      total++;
      if ({g, wrap, step} !== {4'b1011, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL load: g=%b wrap=%b step=%b, want g=1011 wrap=0 step=1",
                  g, wrap, step);
      end
      tick(1'b0, 1'b0, 1'b1, 1'b1, '0);
      total++;
      if ({g, wrap, step} !== {4'b1001, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL load_count: g=%b wrap=%b step=%b, want g=1001 wrap=0 step=1",
                  g, wrap, step);
      end
      // Counter now at 14; step to 15 then load the wrap value 0000 with an up count pending.
      tick(1'b0, 1'b0, 1'b1, 1'b1, '0);
      tick(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
      total++;
      if ({g, wrap, step} !== {4'b0000, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL load_wrap_value: g=%b wrap=%b step=%b, want g=0000 wrap=0 step=1",
                  g, wrap, step);
      end
   endtask

   task automatic test_hold();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 4'b0110);
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), W'($urandom));
         total++;
         if ({g, wrap, step} !== {4'b0110, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL hold[%0d]: g=%b wrap=%b step=%b, want g=0110 wrap=0 step=0",
                     i, g, wrap, step);
         end
      end
   endtask

   task automatic test_downstream_chain();
      int conv;
      tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < N; i++) begin
         tick(1'b0, 1'b0, 1'b1, 1'b1, '0);
         conv = inv[g];
         total++;
         if (conv != (i + 1) % N || conv != m_cnt) begin
            bad++;
            $display("FAIL chain[%0d]: converted=%0d, want %0d (model cnt %0d)",
                     i, conv, (i + 1) % N, m_cnt);
         end
      end
   endtask

   task automatic test_random();
      logic r, l, e, d;
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 19) == 0);
         l = ($urandom_range(0, 7) == 0);
         e = ($urandom_range(0, 3) != 0);
         d = 1'($urandom_range(0, 1));
         tick(r, l, e, d, W'($urandom));
         total++;
         if ({g, wrap, step} !== {gtab[m_cnt], m_wrap, m_step}) begin
            bad++;
            $display("FAIL random[%0d]: g=%b wrap=%b step=%b, want g=%b wrap=%b step=%b",
                     i, g, wrap, step, gtab[m_cnt], m_wrap, m_step);
         end
         if (!r && !l && e) begin
            total++;
            if ($countones(g ^ prev_g) != 1) begin
               bad++;
               $display("FAIL random_onehot[%0d]: g_old=%b g_new=%b, want one bit changed",
                        i, prev_g, g);
            end
         end
      end
   endtask

   initial begin
      build_tables();
      test_reset();
      test_up_sweep();
      test_down_wrap();
      test_load_then_count();
      test_hold();
      test_downstream_chain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous up/down counter that presents its count in Gray code.
- Sits directly upstream of the Gray-to-binary converter and drives its Gray input bus.
- Holds the count internally in binary. The Gray output is registered, so exactly one output bit changes per count step.
- Also provides load, wrap and step-strobe signals for downstream capture logic.

Parameters:
- W, 4, counter width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable; one step per clk while high
- dir  input  1  count direction: 1 = up, 0 = down
- ld  input  1  synchronous load strobe
- ld_g  input  W  Gray-coded value to load
- g  output  W  registered Gray count; feeds the Gray-to-binary converter
- wrap  output  1  one-cycle pulse, registered with the g update that wraps the count
- step  output  1  one-cycle pulse, high in the cycle g holds a newly updated value

Behaviour:
- Reset: sampled on the rising clk edge only.
  - Outputs: g = 0, wrap = 0, step = 0; internal binary count cnt = 0.
  - Reset overrides ld and en in the same cycle.
- Priority per cycle: rst > ld > en. When en = 0 and ld = 0, g and cnt hold; wrap = 0; step = 0.
- Load (ld = 1, rst = 0):
  - cnt <= gray2bin(ld_g), where gray2bin is bin[W-1] = g[W-1] and bin[i] = bin[i+1] ^ g[i].
  - g <= ld_g; step <= 1; wrap <= 0.
  - en and dir are ignored that cycle.
- Count (en = 1, ld = 0, rst = 0):
  - dir = 1: cnt <= cnt + 1 mod 2^W.
  - dir = 0: cnt <= cnt - 1 mod 2^W.
  - g <= next_cnt ^ (next_cnt >> 1); step <= 1.
- Latency: g reflects a count or load exactly 1 clk after the enabling edge. There is no combinational path from inputs to g.
- Wrap:
  - Up count: wrap <= 1 when cnt = 2^W-1 (g = 1 followed by W-1 zeros) and next g = 0.
  - Down count: wrap <= 1 when cnt = 0 and next g = 1 followed by W-1 zeros.
  - Otherwise wrap <= 0. wrap is never asserted on a load, including a load of the wrap value.
- Single-bit-change invariant: for every count step, g_new ^ g_old is one-hot. Loads are exempt.
- dir may change on any cycle. The new direction takes effect on that same edge with no dead cycle.
- Reset mid-operation: any pending load or count is discarded; the next cycle starts from 0.
- All arithmetic is unsigned modulo 2^W. No saturation.

Test Plan (W = 4):
- Reset: rst = 1 for 2 clks with en = 1, ld = 1, ld_g = 1111 -> g = 0000, wrap = 0, step = 0 after each edge.
- Up sweep: dir = 1, en = 1 for 17 clks.
  - g sequence: 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000, 0001.
  - wrap = 1 only on the 0000 cycle; step = 1 throughout.
  - Check popcount(g_new ^ g_old) = 1 every step.
- Down wrap: from g = 0000, dir = 0, en = 1 for 2 clks -> g = 1000 with wrap = 1, then g = 1001 with wrap = 0.
- Load then count: ld = 1, ld_g = 1011 (binary 13), with en = 1, dir = 0 asserted the same cycle.
  - g = 1011, step = 1, wrap = 0 (load wins over the count).
  - Next clk with ld = 0, en = 1, dir = 1 -> g = 1001 (binary 14).
- Hold: en = 0, ld = 0 for 5 clks at g = 0110 -> g stays 0110; step = 0 and wrap = 0 on all 5 cycles.
- Downstream chain: drive the Gray-to-binary converter from g over a full up sweep -> converter output reads 1, 2, ..., 15, 0 one per clk, matching cnt on every cycle.
